// File: rtl/write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// write_buffer : posted write-back FIFO between data cache and memory write port
// Optional WBUF_COALESCE_EN: same-line evictions merge into a buffered entry.
// Revision: 1.0
// ============================================================================
module write_buffer #(
    parameter int DEPTH       = 4,
    parameter int PTR_BITS    = 2,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enqE,
    input  logic [ADDR_BITS-1:0] enqAddr,
    input  logic [DATA_BITS-1:0] enqData,
    output logic                 enqReady,
    input  logic [ADDR_BITS-1:0] lkAddr,
    output logic                 lkHit,
    output logic [DATA_BITS-1:0] lkData,
    output logic [ADDR_BITS-1:0] wAddr,
    output logic                 wE,
    output logic [DATA_BITS-1:0] wData,
    input  logic                 wDone,
    output logic                 empty,
    output logic [PTR_BITS:0]    count
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RETIRE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_BITS-1:0]  ent_addr [DEPTH];
    logic [DATA_BITS-1:0]  ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [PTR_BITS-1:0]   head;
    logic [PTR_BITS-1:0]   tail;
    logic [PTR_BITS:0]     cnt;

    logic                  full;
    logic                  pop;
    logic                  latch;
    logic                  alloc;
    logic                  merge_cand;
    logic                  merge;
    logic [PTR_BITS-1:0]   merge_idx;
    logic [DATA_BITS-1:0]  head_data;
    logic [PTR_BITS-1:0]   lk_idx;
    logic                  unused_lk_offset;

    assign unused_lk_offset = ^lkAddr[OFFSET_BITS-1:0];

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        lkHit  = 1'b0;
        lkData = '0;
        lk_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + PTR_BITS'(i);
            if (ent_valid[lk_idx] &&
                ent_addr[lk_idx][ADDR_BITS-1:OFFSET_BITS] == lkAddr[ADDR_BITS-1:OFFSET_BITS]) begin
                lkHit  = 1'b1;
                lkData = ent_data[lk_idx];
            end
        end
    end

`ifdef WBUF_COALESCE_EN
    logic [PTR_BITS-1:0] mg_idx;

    // The head being written (or just latched in RETIRE) must not be modified.
    always_comb begin
        merge_cand = 1'b0;
        merge_idx  = '0;
        mg_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mg_idx = head + PTR_BITS'(i);
            if (ent_valid[mg_idx] &&
                ent_addr[mg_idx][ADDR_BITS-1:OFFSET_BITS] == enqAddr[ADDR_BITS-1:OFFSET_BITS] &&
                !(i == 0 && state != ST_IDLE)) begin
                merge_cand = 1'b1;
                merge_idx  = mg_idx;
            end
        end
    end

    // A merge into the head on the IDLE latch edge forwards the new data.
    assign head_data = (merge && merge_idx == head) ? enqData : ent_data[head];
`else
    assign merge_cand = 1'b0;
    assign merge_idx  = '0;
    assign head_data  = ent_data[head];
`endif

    assign full     = (cnt == FULL_COUNT);
    assign enqReady = !full || merge_cand;
    assign merge    = enqE && enqReady && merge_cand;
    assign alloc    = enqE && enqReady && !merge_cand;
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign wE       = (state == ST_WRITE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_BITS'(1);
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_BITS'(1);
            end
            cnt <= cnt + {{PTR_BITS{1'b0}}, alloc} - {{PTR_BITS{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[tail] <= enqAddr;
            ent_data[tail] <= enqData;
        end
        if (merge) begin
            ent_data[merge_idx] <= enqData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cnt != '0) begin
                    latch     = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wDone) begin
                    pop       = 1'b1;
                    state_nxt = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                // One low cycle on wE between lines restarts the memory's timer.
                if (cnt != '0) begin
                    latch     = 1'b1;
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wAddr <= '0;
            wData <= '0;
        end else if (latch) begin
            wAddr <= ent_addr[head];
            wData <= head_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_write_buffer : table vectors, hand sequences and a queue-model random run.
module tb_write_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] A0 = 32'h1000, A1 = 32'h2000, A2 = 32'h3000,
                            A3 = 32'h4000, A4 = 32'h5000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enqE = 1'b0;
    logic [31:0]  enqAddr = '0;
    logic [127:0] enqData = '0;
    logic         enqReady;
    logic [31:0]  lkAddr = '0;
    logic         lkHit;
    logic [127:0] lkData;
    logic [31:0]  wAddr;
    logic         wE;
    logic [127:0] wData;
    logic         wDone = 1'b0;
    logic         empty;
    logic [2:0]   count;

    always #5 clk = ~clk;

    write_buffer #(.DEPTH(4), .PTR_BITS(2), .ADDR_BITS(32), .DATA_BITS(128), .OFFSET_BITS(4)) dut (
        .clk(clk), .rst(rst), .enqE(enqE), .enqAddr(enqAddr), .enqData(enqData),
        .enqReady(enqReady), .lkAddr(lkAddr), .lkHit(lkHit), .lkData(lkData),
        .wAddr(wAddr), .wE(wE), .wData(wData), .wDone(wDone), .empty(empty), .count(count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] addr; logic [127:0] data; } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        e;
        logic [31:0] a;
        logic [31:0] lk;
        logic        done;
        logic [2:0]  cnt;
        logic        rdy;
        logic        we;
        logic [31:0] waddr;
        logic        hit;
        logic [31:0] haddr;
    } vec_t;
    vec_t tbl[8];

    logic [127:0] got[$];
    logic [127:0] exp_w[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ldat(input logic [31:0] a);
        return {a, a, a, a};
    endfunction

    task automatic set_in(input logic e, input logic [31:0] a, input logic [127:0] d,
                          input logic [31:0] lk, input logic done);
        enqE = e; enqAddr = a; enqData = d; lkAddr = lk; wDone = done;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, '0, '0, 1'b0);
        rst = 1'b0;
        step();
        step();
        #1;
        chk("rst_enqReady", enqReady, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_lkHit", lkHit, 0);
        chk("rst_lkData", lkData, 0);
        chk("rst_wE", wE, 0);
        chk("rst_wAddr", wAddr, 0);
        chk("rst_wData", wData, 0);
        rst = 1'b1;
        step();
        mq.delete();
    endtask

    task automatic wait_we(input int maxc);
        int n = 0;
        #1;
        while (!wE && n < maxc) begin
            step();
            #1;
            n++;
        end
        chk("wE_timeout", wE, 1);
    endtask

    // Memory completes each write on its first cycle; collects written data.
    task automatic collect(input int ncyc);
        got.delete();
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (wE) got.push_back(wData);
            wDone = wE;
            step();
        end
        wDone = 1'b0;
    endtask

    task automatic cmp_writes(input string nm);
        chk({nm, "_n"}, got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            chk(nm, (i < got.size()) ? got[i] : 128'hDEAD, exp_w[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi;
        int          dly;
        int          lowrun;
        int          uniq;
        logic        popped;
        logic        e;
        logic        done;
        logic        we_pre;
        logic        rdy_pre;
        logic [31:0] a;
        logic [31:0] lk;
        logic [127:0] d;
        logic        mhit;
        logic [127:0] mdat;
        logic        prev;
        logic [31:0] wseen[$];

        tbl[0] = '{1'b1, A0,         A0,         1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, A1,         A0 + 32'h4, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0, 1'b1, A0};
        tbl[2] = '{1'b1, A2,         A3,         1'b0, 3'd2, 1'b1, 1'b1, A0,    1'b0, 32'h0};
        tbl[3] = '{1'b1, A3,         A2 + 32'h8, 1'b0, 3'd3, 1'b1, 1'b1, A0,    1'b1, A2};
        tbl[4] = '{1'b1, A4,         A4,         1'b0, 3'd4, 1'b0, 1'b1, A0,    1'b0, 32'h0};
        tbl[5] = '{1'b1, A4,         A0,         1'b1, 3'd4, 1'b0, 1'b1, A0,    1'b1, A0};
        tbl[6] = '{1'b1, A4,         A0,         1'b0, 3'd3, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 32'h0,      A4 + 32'hC, 1'b0, 3'd4, 1'b0, 1'b1, A1,    1'b1, A4};

        @(negedge clk);
        do_reset();

        // Fill, drop on full, refused enqueue on the pop edge, tail wrap.
        for (int r = 0; r < 8; r++) begin
            set_in(tbl[r].e, tbl[r].a, ldat(tbl[r].a), tbl[r].lk, tbl[r].done);
            #1;
            chk($sformatf("tbl%0d_count", r), count, tbl[r].cnt);
            chk($sformatf("tbl%0d_enqReady", r), enqReady, tbl[r].rdy);
            chk($sformatf("tbl%0d_wE", r), wE, tbl[r].we);
            if (tbl[r].we) chk($sformatf("tbl%0d_wAddr", r), wAddr, tbl[r].waddr);
            chk($sformatf("tbl%0d_lkHit", r), lkHit, tbl[r].hit);
            chk($sformatf("tbl%0d_lkData", r), lkData, tbl[r].hit ? ldat(tbl[r].haddr) : 128'h0);
            step();
        end
        prev = 1'b0;
        wseen.delete();
        for (int c = 0; c < 12; c++) begin
            set_in(1'b0, '0, '0, '0, 1'b1);
            #1;
            if (wE) begin
                wseen.push_back(wAddr);
                chk("drain_gap", prev, 0);
            end
            prev = wE;
            step();
        end
        wDone = 1'b0;
        chk("drain_n", wseen.size(), 4);
        chk("drain0", (wseen.size() > 0) ? wseen[0] : 32'hDEAD, A1);
        chk("drain1", (wseen.size() > 1) ? wseen[1] : 32'hDEAD, A2);
        chk("drain2", (wseen.size() > 2) ? wseen[2] : 32'hDEAD, A3);
        chk("drain3", (wseen.size() > 3) ? wseen[3] : 32'hDEAD, A4);
        #1;
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);

        // Single line, memory answers on the 6th wE cycle.
        do_reset();
        set_in(1'b1, 32'h100, ldat(32'hAAAA_0001), 32'h100, 1'b0);
        step();
        enqE = 1'b0;
        wait_we(5);
        hi = 0;
        for (int c = 0; c < 20 && wE; c++) begin
            hi++;
            chk("single_wAddr", wAddr, 32'h100);
            chk("single_wData", wData, ldat(32'hAAAA_0001));
            wDone = (hi == 6);
            step();
            #1;
        end
        wDone = 1'b0;
        chk("single_hi_cycles", hi, 6);
        chk("single_count", count, 0);
        chk("single_empty", empty, 1);

        // Lookup stays visible through WRITE until the pop edge.
        do_reset();
        set_in(1'b1, 32'h200, ldat(32'hBBBB_0002), 32'h20C, 1'b0);
        step();
        enqE = 1'b0;
        #1;
        chk("lk_idle_hit", lkHit, 1);
        chk("lk_idle_data", lkData, ldat(32'hBBBB_0002));
        wait_we(5);
        for (int c = 0; c < 3; c++) begin
            chk("lk_write_hit", lkHit, 1);
            chk("lk_write_data", lkData, ldat(32'hBBBB_0002));
            step();
            #1;
        end
        wDone = 1'b1;
        chk("lk_popcyc_hit", lkHit, 1);
        step();
        wDone = 1'b0;
        #1;
        chk("lk_after_hit", lkHit, 0);
        chk("lk_after_data", lkData, 0);

        // Asynchronous reset mid-WRITE abandons the line.
        do_reset();
        set_in(1'b1, 32'h700, ldat(32'h7777_0007), 32'h700, 1'b0);
        step();
        enqE = 1'b0;
        wait_we(5);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wE", wE, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_lkHit", lkHit, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            chk("arst_no_wE", wE, 0);
        end
        chk("arst_count_after", count, 0);

        // Same line enqueued twice: merged while head is idle, else two writes.
        do_reset();
        set_in(1'b1, 32'h300, ldat(32'hCCCC_000C), '0, 1'b0);
        step();
        set_in(1'b1, 32'h304, ldat(32'hDDDD_000D), '0, 1'b0);
        step();
        enqE = 1'b0;
        #1;
        exp_w.delete();
`ifdef WBUF_COALESCE_EN
        chk("coal_count", count, 1);
        exp_w.push_back(ldat(32'hDDDD_000D));
`else
        chk("coal_count", count, 2);
        exp_w.push_back(ldat(32'hCCCC_000C));
        exp_w.push_back(ldat(32'hDDDD_000D));
`endif
        collect(12);
        cmp_writes("coal_writes");

        do_reset();
        set_in(1'b1, 32'h300, ldat(32'hCCCC_000C), '0, 1'b0);
        step();
        enqE = 1'b0;
        wait_we(5);
        set_in(1'b1, 32'h300, ldat(32'hDDDD_000D), '0, 1'b0);
        step();
        enqE = 1'b0;
        #1;
        chk("coal_busy_count", count, 2);
        exp_w.delete();
        exp_w.push_back(ldat(32'hCCCC_000C));
        exp_w.push_back(ldat(32'hDDDD_000D));
        collect(12);
        cmp_writes("coal_busy_writes");

        // Random traffic against a FIFO queue model with a variable-latency memory.
        do_reset();
        hi = 0;
        dly = 1 + int'($urandom % 4);
        lowrun = 0;
        popped = 1'b0;
        uniq = 0;
        for (int n = 0; n < 1500; n++) begin
            e = ($urandom % 3) != 0;
`ifdef WBUF_COALESCE_EN
            a  = 32'h10000 + (32'(uniq) << 4) + 32'($urandom % 16);
            lk = 32'h10000 + (32'($urandom % 32'(uniq + 1)) << 4) + 32'($urandom % 16);
            uniq++;
`else
            a  = (32'(($urandom % 6) + 1) << 12) | 32'($urandom % 16);
            lk = (32'($urandom % 8) << 12) | 32'($urandom % 16);
`endif
            d = {$urandom, $urandom, $urandom, $urandom};
            if (wE) hi++; else hi = 0;
            done = wE && (hi >= dly);
            set_in(e, a, d, lk, done);
            #1;
            mhit = 1'b0;
            mdat = '0;
            foreach (mq[i]) begin
                if (mq[i].addr[31:4] == lk[31:4]) begin
                    mhit = 1'b1;
                    mdat = mq[i].data;
                end
            end
            chk("rnd_count", count, mq.size());
            chk("rnd_empty", empty, mq.size() == 0);
            chk("rnd_enqReady", enqReady, mq.size() < DEPTH);
            chk("rnd_lkHit", lkHit, mhit);
            chk("rnd_lkData", lkData, mdat);
            if (wE) begin
                chk("rnd_we_nonempty", mq.size() > 0, 1);
                if (mq.size() > 0) begin
                    chk("rnd_wAddr", wAddr, mq[0].addr);
                    chk("rnd_wData", wData, mq[0].data);
                end
            end
            if (popped) chk("rnd_retire_gap", wE, 0);
            if (mq.size() > 0 && !wE) lowrun++; else lowrun = 0;
            chk("rnd_we_latency", lowrun > 1, 0);
            we_pre = wE;
            rdy_pre = mq.size() < DEPTH;
            @(posedge clk);
            popped = we_pre && done;
            if (popped) begin
                if (mq.size() > 0) void'(mq.pop_front());
                dly = 1 + int'($urandom % 4);
            end
            if (e && rdy_pre) mq.push_back('{a, d});
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
